// File: rtl/imm_gen_stage_pkg.sv
// Shared types for the immediate generation stage:
// format tags, opcodes and the decoded result bundle.
package imm_gen_stage_pkg;

  localparam int ILEN     = 32;
  localparam int XLEN_MAX = 64;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_SH,
    FMT_Z
  } imm_fmt_t;

  localparam logic [6:0] OPCODE_LOAD         = 7'b0000011;
  localparam logic [6:0] OPCODE_I_TYPE_ALU   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC        = 7'b0010111;
  localparam logic [6:0] OPCODE_I_TYPE_ALU32 = 7'b0011011;
  localparam logic [6:0] OPCODE_STORE        = 7'b0100011;
  localparam logic [6:0] OPCODE_LUI          = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH       = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR         = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL          = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM       = 7'b1110011;

  // Fields are sized for RV64; RV32 users take the low half.
  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    imm_fmt_t            fmt;
    logic                illegal;
    logic [ILEN-1:0]     instr;
    logic [XLEN_MAX-1:0] pc;
  } imm_res_t;

  function automatic logic [63:0] sext32(
    input logic [31:0] v
  );
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Fetch-side and issue-side handshake bundle.
// slave: the stage; master: producer/consumer side.
interface imm_gen_stage_if #(
  parameter int XLEN = 32
) ();
  import imm_gen_stage_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  imm_fmt_t        out_fmt;
  logic            out_illegal;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport slave (
    input  in_valid, in_instr, in_pc,
    input  out_ready,
    output in_ready,
    output out_valid, out_imm, out_fmt,
    output out_illegal, out_instr, out_pc
  );

  modport master (
    output in_valid, in_instr, in_pc,
    output out_ready,
    input  in_ready,
    input  out_valid, out_imm, out_fmt,
    input  out_illegal, out_instr, out_pc
  );
endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate decoder: instr_i -> res_o.
// Ports: instr_i, pc_i in; res_o (imm_res_t) out.
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EN_ZIMM = 1'b1
) (
  input  logic [ILEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output imm_res_t        res_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_opi;
  logic       is_sh;
  logic       is_sh32;
  logic       is_i;
  logic       is_s;
  logic       is_b;
  logic       is_u;
  logic       is_j;
  logic       is_z;
  logic       sh_hi;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];

  // funct3 001/101 are the shift encodings
  assign is_opi  = opc == OPCODE_I_TYPE_ALU;
  assign is_sh   = is_opi && f3[1:0] == 2'b01;
  assign is_sh32 = (XLEN == 64)
                && opc == OPCODE_I_TYPE_ALU32
                && f3[1:0] == 2'b01;
  assign is_i    = (is_opi && !is_sh)
                || opc == OPCODE_LOAD
                || opc == OPCODE_JALR
                || ((XLEN == 64)
                    && opc == OPCODE_I_TYPE_ALU32
                    && f3 == 3'b000);
  assign is_s    = opc == OPCODE_STORE;
  assign is_b    = opc == OPCODE_BRANCH;
  assign is_u    = opc == OPCODE_LUI
                || opc == OPCODE_AUIPC;
  assign is_j    = opc == OPCODE_JAL;
  assign is_z    = EN_ZIMM
                && opc == OPCODE_SYSTEM
                && f3[2];

  // bit 25 is shamt[5] only on RV64 OP-IMM
  assign sh_hi = (XLEN == 64) ? instr_i[25] : 1'b0;

  always_comb begin
    res_o         = '0;
    res_o.fmt     = FMT_NONE;
    res_o.instr   = instr_i;
    res_o.pc      = XLEN_MAX'(pc_i);
    unique case (1'b1)
      is_i: begin
        res_o.imm = {{52{instr_i[31]}},
                     instr_i[31:20]};
        res_o.fmt = FMT_I;
      end
      is_sh: begin
        res_o.imm     = {58'b0, sh_hi,
                         instr_i[24:20]};
        res_o.fmt     = FMT_SH;
        res_o.illegal = (XLEN == 32)
                     && instr_i[25];
      end
      is_sh32: begin
        res_o.imm     = {59'b0, instr_i[24:20]};
        res_o.fmt     = FMT_SH;
        res_o.illegal = instr_i[25];
      end
      is_s: begin
        res_o.imm = {{52{instr_i[31]}},
                     instr_i[31:25],
                     instr_i[11:7]};
        res_o.fmt = FMT_S;
      end
      is_b: begin
        res_o.imm = {{52{instr_i[31]}},
                     instr_i[7],
                     instr_i[30:25],
                     instr_i[11:8], 1'b0};
        res_o.fmt = FMT_B;
      end
      is_u: begin
        res_o.imm = sext32({instr_i[31:12],
                            12'b0});
        res_o.fmt = FMT_U;
      end
      is_j: begin
        res_o.imm = {{44{instr_i[31]}},
                     instr_i[19:12],
                     instr_i[20],
                     instr_i[30:21], 1'b0};
        res_o.fmt = FMT_J;
      end
      is_z: begin
        res_o.imm = {59'b0, instr_i[19:15]};
        res_o.fmt = FMT_Z;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate stage with optional skid entry.
// Ports: clk, rst, flush_i, bus (imm_gen_stage_if.slave).
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SKID    = 1,
  parameter bit EN_ZIMM = 1'b1
) (
  input logic             clk,
  input logic             rst,
  input logic             flush_i,
  imm_gen_stage_if.slave  bus
);

  imm_res_t dec_res;
  imm_res_t out_q, out_d;
  imm_res_t skid_q, skid_d;
  logic     out_valid_q, out_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     in_ready;
  logic     accept;
  logic     drain;

  imm_decode #(
    .XLEN    (XLEN),
    .EN_ZIMM (EN_ZIMM)
  ) u_dec (
    .instr_i (bus.in_instr),
    .pc_i    (bus.in_pc),
    .res_o   (dec_res)
  );

  // Skid variant keeps in_ready off a flop so it
  // never depends on out_ready combinationally.
  assign in_ready = (SKID != 0)
                  ? !skid_valid_q
                  : (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign drain    = out_valid_q && bus.out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (SKID != 0) begin
      // accept is never true with skid full
      if (drain && skid_valid_q) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else if (drain && accept) begin
        out_d = dec_res;
      end else if (drain) begin
        out_valid_d = 1'b0;
      end else if (accept && out_valid_q) begin
        skid_d       = dec_res;
        skid_valid_d = 1'b1;
      end else if (accept) begin
        out_d       = dec_res;
        out_valid_d = 1'b1;
      end
    end else begin
      if (accept) begin
        out_d       = dec_res;
        out_valid_d = 1'b1;
      end else if (drain) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_q.imm[XLEN-1:0];
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;
  assign bus.out_instr   = out_q.instr;
  assign bus.out_pc      = out_q.pc[XLEN-1:0];

  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{out_q.imm[XLEN_MAX-1:XLEN],
                         out_q.pc[XLEN_MAX-1:XLEN]};
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Randomized and directed bench for imm_gen_stage,
// RV32 and RV64 instances driven in lockstep.
module tb_imm_gen_stage;
  import imm_gen_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32)) i32 ();
  imm_gen_stage_if #(.XLEN(64)) i64 ();

  imm_gen_stage #(
    .XLEN(32), .SKID(1), .EN_ZIMM(1'b1)
  ) u_dut32 (
    .clk(clk), .rst(rst),
    .flush_i(flush), .bus(i32)
  );

  imm_gen_stage #(
    .XLEN(64), .SKID(1), .EN_ZIMM(1'b1)
  ) u_dut64 (
    .clk(clk), .rst(rst),
    .flush_i(flush), .bus(i64)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } beat_t;

  beat_t q32[$];
  beat_t q64[$];

  function automatic longint u(input logic [31:0] x);
    return longint'({32'b0, x});
  endfunction

  // Value-level model: each format is the signed
  // integer the ISA manual describes.
  function automatic void ref_dec(
    input  logic [31:0] ins,
    input  int          xl,
    output logic [63:0] imm,
    output logic [2:0]  fmt,
    output logic        ill
  );
    longint     v;
    logic [6:0] opc;
    logic [2:0] f3;
    bit         shf;
    v   = 0;
    fmt = FMT_NONE;
    ill = 1'b0;
    opc = ins[6:0];
    f3  = ins[14:12];
    shf = (f3 == 3'd1) || (f3 == 3'd5);
    case (opc)
      7'h13, 7'h03, 7'h67: begin
        if (opc == 7'h13 && shf) begin
          v   = (xl == 64) ? u(ins[25:20])
                           : u(ins[24:20]);
          fmt = FMT_SH;
          ill = (xl == 32) && ins[25];
        end else begin
          v = u(ins[31:20]);
          if (v >= 2048) v -= 4096;
          fmt = FMT_I;
        end
      end
      7'h1B: begin
        if (xl == 64 && shf) begin
          v   = u(ins[24:20]);
          fmt = FMT_SH;
          ill = ins[25];
        end else if (xl == 64 && f3 == 3'd0) begin
          v = u(ins[31:20]);
          if (v >= 2048) v -= 4096;
          fmt = FMT_I;
        end
      end
      7'h23: begin
        v = u(ins[31:25]) * 32 + u(ins[11:7]);
        if (ins[31]) v -= 4096;
        fmt = FMT_S;
      end
      7'h63: begin
        v = u(ins[7]) * 2048 + u(ins[30:25]) * 32
          + u(ins[11:8]) * 2;
        if (ins[31]) v -= 4096;
        fmt = FMT_B;
      end
      7'h37, 7'h17: begin
        v = u(ins[30:12]) * 4096;
        if (ins[31]) v -= 64'd2147483648;
        fmt = FMT_U;
      end
      7'h6F: begin
        v = u(ins[19:12]) * 4096 + u(ins[20]) * 2048
          + u(ins[30:21]) * 2;
        if (ins[31]) v -= 64'd1048576;
        fmt = FMT_J;
      end
      7'h73: begin
        if (ins[14]) begin
          v   = u(ins[19:15]);
          fmt = FMT_Z;
        end
      end
      default: ;
    endcase
    imm = 64'(v);
    if (xl == 32) imm[63:32] = 32'b0;
  endfunction

  task automatic cmp_out(
    input int          xl,
    input beat_t       b,
    input logic [63:0] imm,
    input logic [2:0]  fmt,
    input logic        ill,
    input logic [31:0] ins,
    input logic [63:0] pc
  );
    logic [63:0] ei;
    logic [2:0]  ef;
    logic        el;
    logic [63:0] ep;
    ref_dec(b.instr, xl, ei, ef, el);
    ep = b.pc;
    if (xl == 32) ep[63:32] = 32'b0;
    check($sformatf("imm%0d", xl), imm, ei);
    check($sformatf("fmt%0d", xl),
          64'(fmt), 64'(ef));
    check($sformatf("ill%0d", xl),
          64'(ill), 64'(el));
    check($sformatf("instr%0d", xl),
          64'(ins), 64'(b.instr));
    check($sformatf("pc%0d", xl), pc, ep);
  endtask

  task automatic step(
    input logic        v,
    input logic [31:0] ins,
    input logic [63:0] pc,
    input logic        ordy,
    input logic        fl
  );
    beat_t       b;
    logic        a32, a64, s32, s64;
    logic [63:0] hi32, hp32, hi64, hp64;
    logic [31:0] hn32, hn64;
    i32.in_valid  = v;
    i32.in_instr  = ins;
    i32.in_pc     = pc[31:0];
    i32.out_ready = ordy;
    i64.in_valid  = v;
    i64.in_instr  = ins;
    i64.in_pc     = pc;
    i64.out_ready = ordy;
    flush         = fl;
    #1;
    if (i32.out_valid && ordy) begin
      if (q32.size() == 0) begin
        check("spurious32", 64'(i32.out_valid), 64'd0);
      end else begin
        b = q32.pop_front();
        cmp_out(32, b, 64'(i32.out_imm),
                i32.out_fmt, i32.out_illegal,
                i32.out_instr, 64'(i32.out_pc));
      end
    end
    if (i64.out_valid && ordy) begin
      if (q64.size() == 0) begin
        check("spurious64", 64'(i64.out_valid), 64'd0);
      end else begin
        b = q64.pop_front();
        cmp_out(64, b, i64.out_imm,
                i64.out_fmt, i64.out_illegal,
                i64.out_instr, i64.out_pc);
      end
    end
    a32  = v && i32.in_ready;
    a64  = v && i64.in_ready;
    s32  = i32.out_valid && !ordy && !fl;
    s64  = i64.out_valid && !ordy && !fl;
    hi32 = 64'(i32.out_imm);
    hp32 = 64'(i32.out_pc);
    hn32 = i32.out_instr;
    hi64 = i64.out_imm;
    hp64 = i64.out_pc;
    hn64 = i64.out_instr;
    @(posedge clk);
    if (fl) begin
      q32.delete();
      q64.delete();
    end else begin
      if (a32) q32.push_back('{ins, pc});
      if (a64) q64.push_back('{ins, pc});
    end
    @(negedge clk);
    if (s32) begin
      check("hold_v32", 64'(i32.out_valid), 64'd1);
      check("hold_imm32", 64'(i32.out_imm), hi32);
      check("hold_ins32", 64'(i32.out_instr),
            64'(hn32));
      check("hold_pc32", 64'(i32.out_pc), hp32);
    end
    if (s64) begin
      check("hold_v64", 64'(i64.out_valid), 64'd1);
      check("hold_imm64", i64.out_imm, hi64);
      check("hold_ins64", 64'(i64.out_instr),
            64'(hn64));
      check("hold_pc64", i64.out_pc, hp64);
    end
    check("occ_rdy32", 64'(i32.in_ready),
          64'(q32.size() < 2));
    check("occ_vld32", 64'(i32.out_valid),
          64'(q32.size() > 0));
    check("occ_rdy64", 64'(i64.in_ready),
          64'(q64.size() < 2));
    check("occ_vld64", 64'(i64.out_valid),
          64'(q64.size() > 0));
  endtask

  task automatic do_reset(input logic v);
    rst           = 1'b1;
    flush         = 1'b0;
    i32.in_valid  = v;
    i64.in_valid  = v;
    i32.in_instr  = 32'h00500093;
    i64.in_instr  = 32'h00500093;
    i32.out_ready = 1'b0;
    i64.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    q32.delete();
    q64.delete();
    check("rst_vld32", 64'(i32.out_valid), 64'd0);
    check("rst_imm32", 64'(i32.out_imm), 64'd0);
    check("rst_fmt32", 64'(i32.out_fmt), 64'd0);
    check("rst_ill32", 64'(i32.out_illegal), 64'd0);
    check("rst_ins32", 64'(i32.out_instr), 64'd0);
    check("rst_pc32", 64'(i32.out_pc), 64'd0);
    check("rst_vld64", 64'(i64.out_valid), 64'd0);
    check("rst_imm64", i64.out_imm, 64'd0);
    check("rst_pc64", i64.out_pc, 64'd0);
    rst          = 1'b0;
    i32.in_valid = 1'b0;
    i64.in_valid = 1'b0;
    #1;
    check("rst_rdy32", 64'(i32.in_ready), 64'd1);
    check("rst_rdy64", 64'(i64.in_ready), 64'd1);
  endtask

  logic [31:0] vec [6] = '{
    32'hFFF00093, 32'h800000B7, 32'hFE000CE3,
    32'hFFDFF06F, 32'h02009093, 32'h300FD073
  };
  logic [63:0] e32 [6] = '{
    64'hFFFFFFFF, 64'h80000000, 64'hFFFFFFF8,
    64'hFFFFFFFC, 64'h0, 64'h1F
  };
  logic [63:0] e64 [6] = '{
    64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000,
    64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC,
    64'h20, 64'h1F
  };
  logic [2:0] ef [6] = '{
    FMT_I, FMT_U, FMT_B, FMT_J, FMT_SH, FMT_Z
  };
  logic l32 [6] = '{0, 0, 0, 0, 1, 0};

  logic [6:0] ops [10] = '{
    7'h13, 7'h03, 7'h67, 7'h1B, 7'h23,
    7'h63, 7'h37, 7'h17, 7'h6F, 7'h73
  };

  function automatic logic [31:0] rnd_instr();
    logic [31:0] ins;
    int          k;
    ins = $urandom;
    k   = $urandom_range(0, 10);
    if (k < 10) ins[6:0] = ops[k];
    if (ins[6:0] == 7'h1B) begin
      case ($urandom_range(0, 2))
        0:       ins[14:12] = 3'd0;
        1:       ins[14:12] = 3'd1;
        default: ins[14:12] = 3'd5;
      endcase
    end
    return ins;
  endfunction

  localparam logic [31:0] A = 32'h00500093;
  localparam logic [31:0] B = 32'h00A00113;
  localparam logic [31:0] C = 32'h00F00193;
  localparam logic [31:0] D = 32'h00100213;
  localparam logic [31:0] E = 32'h12345037;

  initial begin
    i32.in_valid  = 1'b0;
    i32.in_instr  = '0;
    i32.in_pc     = '0;
    i32.out_ready = 1'b0;
    i64.in_valid  = 1'b0;
    i64.in_instr  = '0;
    i64.in_pc     = '0;
    i64.out_ready = 1'b0;

    do_reset(1'b1);

    for (int i = 0; i < 6; i++) begin
      step(1'b1, vec[i], 64'h1000 + 64'(i * 4),
           1'b1, 1'b0);
      check("lat_vld32", 64'(i32.out_valid), 64'd1);
      check("vec_imm32", 64'(i32.out_imm), e32[i]);
      check("vec_fmt32", 64'(i32.out_fmt),
            64'(ef[i]));
      check("vec_ill32", 64'(i32.out_illegal),
            64'(l32[i]));
      check("vec_imm64", i64.out_imm, e64[i]);
      check("vec_fmt64", 64'(i64.out_fmt),
            64'(ef[i]));
      check("vec_ill64", 64'(i64.out_illegal), 64'd0);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);

    step(1'b1, A, 64'h100, 1'b0, 1'b0);
    step(1'b1, B, 64'h104, 1'b0, 1'b0);
    check("skid_rdy", 64'(i32.in_ready), 64'd0);
    check("skid_a", 64'(i32.out_instr), 64'(A));
    step(1'b1, C, 64'h108, 1'b0, 1'b0);
    check("skid_stall", 64'(i32.out_instr), 64'(A));
    step(1'b1, C, 64'h108, 1'b1, 1'b0);
    check("skid_b32", 64'(i32.out_instr), 64'(B));
    check("skid_b64", 64'(i64.out_instr), 64'(B));
    step(1'b1, C, 64'h108, 1'b1, 1'b0);
    check("skid_c32", 64'(i32.out_instr), 64'(C));
    check("skid_c64", 64'(i64.out_instr), 64'(C));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("skid_empty", 64'(i32.out_valid), 64'd0);

    step(1'b1, A, 64'h200, 1'b0, 1'b0);
    step(1'b1, B, 64'h204, 1'b0, 1'b0);
    step(1'b1, D, 64'h208, 1'b0, 1'b1);
    check("fl_vld32", 64'(i32.out_valid), 64'd0);
    check("fl_rdy32", 64'(i32.in_ready), 64'd1);
    check("fl_vld64", 64'(i64.out_valid), 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("fl_gone", 64'(i32.out_valid), 64'd0);
    step(1'b1, A, 64'h300, 1'b0, 1'b0);
    step(1'b1, D, 64'h304, 1'b0, 1'b1);
    check("fl_win", 64'(i32.out_valid), 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("fl_win2", 64'(i32.out_valid), 64'd0);

    step(1'b1, A, 64'h400, 1'b0, 1'b0);
    step(1'b1, B, 64'h404, 1'b0, 1'b0);
    do_reset(1'b1);
    step(1'b1, E, 64'h500, 1'b1, 1'b0);
    check("post_vld", 64'(i32.out_valid), 64'd1);
    check("post_ins", 64'(i32.out_instr), 64'(E));
    check("post_imm32", 64'(i32.out_imm),
          64'h12345000);
    check("post_imm64", i64.out_imm, 64'h12345000);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)),
           rnd_instr(),
           {$urandom, $urandom},
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 49) == 0));
    end
    for (int n = 0; n < 3; n++)
      step(1'b0, '0, '0, 1'b1, 1'b0);
    check("drain32", 64'(q32.size()), 64'd0);
    check("drain64", 64'(q64.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
